// File: rtl/control_pipe.sv
// Main decode plus ID/EX, EX/MEM, MEM/WB control registers with load-use stall and flush bubbles.
// Define CONTROL_PIPE_JUMP_EN to decode JAL, JALR, LUI and AUIPC; otherwise they are illegal.

package control_pipe_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
  } ctrl_t;

endpackage

module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_alusrc_o,
  output logic              ex_branch_o,
  output logic              ex_jump_o,
  output logic              ex_jalr_o,
  output logic              ex_illegal_o,
  output logic [1:0]        ex_aluop_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  output logic              mem_regwrite_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic              wb_regwrite_o,
  output logic [1:0]        wb_resultsrc_o,
  output logic [REG_AW-1:0] wb_rd_o
);

`ifdef CONTROL_PIPE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  ctrl_t             dec;
  logic [REG_AW-1:0] dec_rd;
  logic              rs1_used;
  logic              rs2_used;

  ctrl_t             id_ex;
  logic [REG_AW-1:0] id_ex_rd;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              mem_regwrite;
  logic [1:0]        mem_resultsrc;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_regwrite;
  logic [1:0]        wb_resultsrc;
  logic [REG_AW-1:0] wb_rd;

  // Main decode; unknown opcodes collapse to an otherwise empty bundle flagged illegal
  always_comb begin
    dec    = '0;
    dec_rd = '0;
    if (id_valid_i) begin
      dec.valid = 1'b1;
      dec_rd    = id_rd_i;
      case (id_opcode_i)
        OP_R:   begin dec.regwrite = 1'b1; dec.aluop = 2'b10; end
        OP_I:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10; end
        OP_LW:  begin
          dec.alusrc    = 1'b1;
          dec.memread   = 1'b1;
          dec.regwrite  = 1'b1;
          dec.resultsrc = 2'b01;
        end
        OP_SW:  begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
        OP_BEQ: begin dec.branch = 1'b1; dec.aluop = 2'b01; end
`ifdef CONTROL_PIPE_JUMP_EN
        OP_JAL: begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.resultsrc = 2'b10; end
        OP_JALR: begin
          dec.jump      = 1'b1;
          dec.jalr      = 1'b1;
          dec.alusrc    = 1'b1;
          dec.regwrite  = 1'b1;
          dec.resultsrc = 2'b10;
        end
        OP_LUI, OP_AUIPC: begin
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          dec.aluop    = 2'b11;
        end
`endif
        default: begin
          dec         = '0;
          dec.illegal = 1'b1;
          dec_rd      = '0;
        end
      endcase
      if (id_rd_i == '0) dec.regwrite = 1'b0;
    end
  end

  always_comb begin
    rs1_used = !(id_opcode_i inside {OP_LUI, OP_JAL, OP_AUIPC});
    rs2_used = id_opcode_i inside {OP_R, OP_SW, OP_BEQ};
  end

  // Load-use: the load in EX targets a register the ID instruction reads
  assign stall_o = ~reset & id_valid_i & ~flush_i & id_ex.valid & id_ex.memread
                 & (id_ex_rd != '0)
                 & ((rs1_used & (id_ex_rd == id_rs1_i)) | (rs2_used & (id_ex_rd == id_rs2_i)));

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex         <= '0;
      id_ex_rd      <= '0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_regwrite  <= 1'b0;
      mem_resultsrc <= 2'b00;
      mem_rd        <= '0;
      wb_regwrite   <= 1'b0;
      wb_resultsrc  <= 2'b00;
      wb_rd         <= '0;
    end else begin
      if (flush_i || stall_o) begin
        id_ex    <= '0;
        id_ex_rd <= '0;
      end else begin
        id_ex    <= dec;
        id_ex_rd <= dec_rd;
      end
      mem_memread   <= id_ex.memread;
      mem_memwrite  <= id_ex.memwrite;
      mem_regwrite  <= id_ex.regwrite;
      mem_resultsrc <= id_ex.resultsrc;
      mem_rd        <= id_ex_rd;
      wb_regwrite   <= mem_regwrite;
      wb_resultsrc  <= mem_resultsrc;
      wb_rd         <= mem_rd;
    end
  end

  assign ex_valid_o     = id_ex.valid;
  assign ex_alusrc_o    = id_ex.alusrc;
  assign ex_branch_o    = id_ex.branch;
  assign ex_jump_o      = JUMP_EN & id_ex.jump;
  assign ex_jalr_o      = JUMP_EN & id_ex.jalr;
  assign ex_illegal_o   = id_ex.illegal;
  assign ex_aluop_o     = id_ex.aluop;
  assign ex_rd_o        = id_ex_rd;
  assign mem_memread_o  = mem_memread;
  assign mem_memwrite_o = mem_memwrite;
  assign mem_regwrite_o = mem_regwrite;
  assign mem_rd_o       = mem_rd;
  assign wb_regwrite_o  = wb_regwrite;
  assign wb_resultsrc_o = wb_resultsrc;
  assign wb_rd_o        = wb_rd;

endmodule

// File: tb/tb_control_pipe.sv
// Randomised bench for control_pipe against a queue-based model of the stage history.
module tb_control_pipe;

  localparam int unsigned AW = 5;
  localparam bit [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam bit [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam bit [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid_i = 1'b0;
  logic [6:0] id_opcode_i = '0;
  logic [AW-1:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic flush_i = 1'b0;
  logic stall_o, ex_valid_o, ex_alusrc_o, ex_branch_o, ex_jump_o, ex_jalr_o, ex_illegal_o;
  logic [1:0] ex_aluop_o, wb_resultsrc_o;
  logic [AW-1:0] ex_rd_o, mem_rd_o, wb_rd_o;
  logic mem_memread_o, mem_memwrite_o, mem_regwrite_o, wb_regwrite_o;

  control_pipe #(.REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .ex_jalr_o(ex_jalr_o),
    .ex_illegal_o(ex_illegal_o), .ex_aluop_o(ex_aluop_o), .ex_rd_o(ex_rd_o),
    .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
    .mem_regwrite_o(mem_regwrite_o), .mem_rd_o(mem_rd_o), .wb_regwrite_o(wb_regwrite_o),
    .wb_resultsrc_o(wb_resultsrc_o), .wb_rd_o(wb_rd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid, alusrc, branch, jump, jalr, illegal;
    bit [1:0] aluop;
    bit memread, memwrite, regwrite;
    bit [1:0] resultsrc;
    bit [AW-1:0] rd;
  } ent_t;

  ent_t hist[$];   // hist[0] = in EX, hist[1] = in MEM, hist[2] = in WB
  int n_checks = 0;
  int n_fail = 0;
  bit last_stall = 1'b0;
  bit [6:0] ops [12] = '{R, I, LW, SW, BEQ, JAL, JALR, LUI, AUIPC, BAD, 7'b0000000, 7'b0001111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t bubble();
    ent_t e = '{default: 0};
    return e;
  endfunction

  function automatic ent_t model_decode(bit v, bit [6:0] op, bit [AW-1:0] rd);
    ent_t e = bubble();
    if (!v) return e;
    e.valid = 1; e.rd = rd;
    case (op)
      R:   begin e.regwrite = 1; e.aluop = 2; end
      I:   begin e.alusrc = 1; e.regwrite = 1; e.aluop = 2; end
      LW:  begin e.alusrc = 1; e.memread = 1; e.regwrite = 1; e.resultsrc = 1; end
      SW:  begin e.alusrc = 1; e.memwrite = 1; end
      BEQ: begin e.branch = 1; e.aluop = 1; end
`ifdef CONTROL_PIPE_JUMP_EN
      JAL:  begin e.jump = 1; e.regwrite = 1; e.resultsrc = 2; end
      JALR: begin e.jump = 1; e.jalr = 1; e.alusrc = 1; e.regwrite = 1; e.resultsrc = 2; end
      LUI, AUIPC: begin e.alusrc = 1; e.regwrite = 1; e.aluop = 3; end
`endif
      default: begin
        e = bubble();
        e.illegal = 1;
        return e;
      end
    endcase
    if (rd == 0) e.regwrite = 0;
    return e;
  endfunction

  function automatic bit model_stall(bit rst, bit v, bit f, bit [6:0] op,
                                     bit [AW-1:0] a, bit [AW-1:0] b);
    ent_t e = hist[0];
    bit use1 = !(op == LUI || op == JAL || op == AUIPC);
    bit use2 = (op == R || op == SW || op == BEQ);
    return !rst && v && !f && e.valid && e.memread && e.rd != 0 &&
           ((use1 && e.rd == a) || (use2 && e.rd == b));
  endfunction

  // One clock: drive ID, check stall before the edge, advance model, check stage outputs
  task automatic step(input bit rst, input bit v, input bit f, input bit [6:0] op,
                      input bit [AW-1:0] a, input bit [AW-1:0] b, input bit [AW-1:0] d);
    bit st;
    ent_t nx;
    ent_t ex, mm, wb;
    reset = rst; id_valid_i = v; flush_i = f; id_opcode_i = op;
    id_rs1_i = a; id_rs2_i = b; id_rd_i = d;
    st = model_stall(rst, v, f, op, a, b);
    @(negedge clk);
    check("stall", 32'(stall_o), 32'(st));
    last_stall = st;
    @(posedge clk);
    if (rst) begin
      hist = {bubble(), bubble(), bubble()};
    end else begin
      nx = (f || st) ? bubble() : model_decode(v, op, d);
      hist.push_front(nx);
      void'(hist.pop_back());
    end
    #1;
    ex = hist[0]; mm = hist[1]; wb = hist[2];
    check("ex_ctrl", 32'({ex_valid_o, ex_alusrc_o, ex_branch_o, ex_jump_o, ex_jalr_o,
                          ex_illegal_o, ex_aluop_o}),
          32'({ex.valid, ex.alusrc, ex.branch, ex.jump, ex.jalr, ex.illegal, ex.aluop}));
    check("ex_rd", 32'(ex_rd_o), 32'(ex.rd));
    check("mem_ctrl", 32'({mem_memread_o, mem_memwrite_o, mem_regwrite_o}),
          32'({mm.memread, mm.memwrite, mm.regwrite}));
    check("mem_rd", 32'(mem_rd_o), 32'(mm.rd));
    check("wb_ctrl", 32'({wb_regwrite_o, wb_resultsrc_o}), 32'({wb.regwrite, wb.resultsrc}));
    check("wb_rd", 32'(wb_rd_o), 32'(wb.rd));
  endtask

  task automatic nop();
    step(0, 0, 0, 7'd0, 0, 0, 0);
  endtask

  initial begin
    bit v, f, r;
    bit [6:0] op;
    bit [AW-1:0] a, b, d;
    hist = {bubble(), bubble(), bubble()};
    @(posedge clk); #1;

    // Reset held two cycles with a live R-type in ID
    step(1, 1, 0, R, 1, 2, 7);
    step(1, 1, 0, R, 1, 2, 7);
    check("rst_ex_valid", 32'(ex_valid_o), 0);
    check("rst_wb_rd", 32'(wb_rd_o), 0);
    step(0, 1, 0, R, 1, 2, 7);
    check("first_ex_valid", 32'(ex_valid_o), 1);
    check("first_ex_aluop", 32'(ex_aluop_o), 2);

    // LW, ADD, SW back to back with no dependence
    step(0, 1, 0, LW, 1, 0, 5);
    check("pipe_lw_ex", 32'({ex_alusrc_o, ex_aluop_o}), 32'({1'b1, 2'b00}));
    step(0, 1, 0, R, 2, 7, 6);
    check("pipe_add_ex", 32'(ex_aluop_o), 2);
    step(0, 1, 0, SW, 2, 8, 0);
    check("pipe_sw_ex", 32'(ex_alusrc_o), 1);
    check("pipe_lw_wb", 32'({wb_resultsrc_o, wb_rd_o}), 32'({2'b01, 5'd5}));
    nop(); nop();

    // Load-use through rs2, then the same with rd=0
    step(0, 1, 0, LW, 1, 0, 3);
    step(0, 1, 0, R, 1, 3, 6);
    check("lu_stall_seen", 32'(last_stall), 1);
    check("lu_bubble", 32'(ex_valid_o), 0);
    step(0, 1, 0, R, 1, 3, 6);
    check("lu_clear", 32'(last_stall), 0);
    check("lu_add_ex", 32'({ex_valid_o, ex_rd_o}), 32'({1'b1, 5'd6}));
    step(0, 1, 0, LW, 1, 0, 0);
    step(0, 1, 0, R, 0, 0, 6);
    check("lu_rd0_nostall", 32'(ex_valid_o), 1);

    // Flush beats a simultaneous hazard; the load in EX still proceeds
    step(0, 1, 0, LW, 1, 0, 4);
    step(0, 1, 1, R, 4, 2, 9);
    check("flush_bubble", 32'(ex_valid_o), 0);
    check("flush_lw_mem", 32'(mem_memread_o), 1);
    step(0, 1, 1, I, 1, 0, 2);
    check("flush2_bubble", 32'(ex_valid_o), 0);
    nop();

    // Illegal opcode
    step(0, 1, 0, BAD, 1, 2, 5);
    check("ill_flag", 32'(ex_illegal_o), 1);
    nop(); nop();

    // JAL rd=1
    step(0, 1, 0, JAL, 0, 0, 1);
`ifdef CONTROL_PIPE_JUMP_EN
    check("jal_jump", 32'(ex_jump_o), 1);
`else
    check("jal_illegal", 32'(ex_illegal_o), 1);
`endif
    nop(); nop();
`ifdef CONTROL_PIPE_JUMP_EN
    check("jal_wb_src", 32'(wb_resultsrc_o), 2);
`else
    check("jal_wb_rw", 32'(wb_regwrite_o), 0);
`endif

    // Reset mid-stream discards in-flight bundles
    step(0, 1, 0, LW, 1, 0, 7);
    step(0, 1, 0, R, 2, 3, 8);
    step(1, 1, 0, LW, 7, 0, 7);
    check("midrst_mem_rw", 32'(mem_regwrite_o), 0);

    // Random traffic; the instruction is held in ID while a stall is reported
    v = 0; op = '0; a = '0; b = '0; d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        v  = ($urandom_range(7) != 0);
        op = ops[$urandom_range(11)];
        a  = AW'($urandom_range(3));
        b  = AW'($urandom_range(3));
        d  = AW'($urandom_range(3));
      end
      f = ($urandom_range(7) == 0);
      r = ($urandom_range(149) == 0);
      step(r, v, f, op, a, b, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined main-decode and control-propagation unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and inserts bubbles on stall or branch flush. It generalises the single-cycle decoder with register-address parametrisation, an optional jump/upper-immediate opcode set, and illegal-opcode flagging.

## Interface
- REG_AW, 5, register-address width for rs1/rs2/rd
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high; clears all stage registers
- id_valid_i  in  1  ID stage holds a live instruction
- id_opcode_i  in  7  instruction[6:0] in ID
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW each  source/destination fields in ID
- flush_i  in  1  branch/jump taken, resolved in EX; kill ID-stage instruction
- stall_o  out  1  load-use hazard; hold PC and IF/ID
- ex_valid_o, ex_alusrc_o, ex_branch_o, ex_jump_o, ex_jalr_o, ex_illegal_o  out  1 each  EX-stage controls
- ex_aluop_o  out  2  00 add (LW/SW/JALR), 01 branch compare, 10 R/I funct decode, 11 pass-B (LUI/AUIPC)
- ex_rd_o  out  REG_AW
- mem_memread_o, mem_memwrite_o, mem_regwrite_o  out  1 each
- mem_rd_o  out  REG_AW  for the forwarding unit
- wb_regwrite_o  out  1;  wb_resultsrc_o  out  2  00 ALU, 01 memory, 10 PC+4;  wb_rd_o  out  REG_AW

## Operation
- Decode (combinational, in ID):
  - R 0110011: regwrite, aluop=10.
  - I 0010011: alusrc, regwrite, aluop=10.
  - LW 0000011: alusrc, memread, regwrite, resultsrc=01.
  - SW 0100011: alusrc, memwrite.
  - BEQ 1100011: branch, aluop=01.
- Any other opcode with id_valid_i=1 produces an all-zero bundle with illegal=1. Bundle is all-zero when id_valid_i=0.
- rd uses: regwrite forced 0 when id_rd_i==0. rs2 is used only by R, SW and BEQ. rs1 is used by all except LUI, JAL and AUIPC.
- Hazard: stall_o = ID/EX.memread & ID/EX.valid & (ID/EX.rd!=0) & ((rs1 used & rd==rs1) | (rs2 used & rd==rs2)) & id_valid_i & ~flush_i.
- ID/EX load, per clk edge, in priority order:
  - reset: cleared.
  - flush_i: bubble.
  - stall_o: bubble.
  - otherwise: decoded bundle.
- EX/MEM and MEM/WB always advance and never stall. A flush does not kill the instruction already in EX.
- Bubble: valid=0 with every control and rd equal to 0.

## Timing
- Bundle decoded in cycle N appears on ex_* in N+1, mem_* in N+2 and wb_* in N+3.
- stall_o is combinational from ID inputs and ID/EX state, with no added latency. It asserts for exactly one cycle per load-use pair; after the bubble the hazard clears.
- Reset is synchronous: all outputs are 0 after the first clk edge with reset=1, and stall_o=0 during reset. Reset mid-stream discards all in-flight bundles.
- Simultaneous flush_i and hazard: flush wins, stall_o=0, bubble inserted.
- Back-to-back flushes give consecutive bubbles.

## Configuration
- CONTROL_PIPE_JUMP_EN defined adds four decodes:
  - JAL 1101111: jump, regwrite, resultsrc=10.
  - JALR 1100111: jump, jalr, alusrc, regwrite, resultsrc=10, aluop=00.
  - LUI 0110111: alusrc, regwrite, aluop=11.
  - AUIPC 0010111: alusrc, regwrite, aluop=11.
- Undefined: these four opcodes are illegal. ex_jump_o and ex_jalr_o are tied to 0, and wb_resultsrc_o never equals 10.

## Test plan
- Reset: hold reset 2 cycles with id_valid_i=1 and opcode=0110011. All outputs are 0 and stall_o=0. The first bundle appears on ex_* one cycle after release.
- Pipeline: issue LW rd=5, then ADD rd=6, then SW, back-to-back with no hazard.
  - ex_* sequence: alusrc=1/aluop=00, then aluop=10, then alusrc=1.
  - wb_resultsrc_o=01 with wb_rd_o=5 three cycles after the LW.
- Load-use: LW rd=3, then ADD rs2=3. stall_o=1 for one cycle, ex_valid_o=0 for one cycle, then the ADD reaches EX. Repeat with rd=0: no stall.
- Flush priority: LW rd=4 in EX, ID holds ADD rs1=4, flush_i=1. stall_o=0 and the next ex_valid_o=0. The LW still reaches mem_memread_o=1.
- Illegal: opcode 1111111 with valid gives ex_illegal_o=1 and all other ex_*/mem_*/wb_* controls 0.
- Macro: JAL rd=1.
  - With CONTROL_PIPE_JUMP_EN: ex_jump_o=1 and wb_resultsrc_o=10.
  - Without: ex_illegal_o=1 and wb_regwrite_o=0.
